m68k_bus_initiator: RTL and testbench
=====================================

Name: m68k_bus_initiator

Overview:
- 68000-style asynchronous bus-cycle initiator. Issues one read or write cycle per local request: drives as_n/uds_n/lds_n/rw, waits for dtack_n or berr_n from the CPLD responders (DTACK generator, DUART), then closes the cycle.
- Used as the CPLD-side test/DMA master and as the bench driver for the DTACK responder logic.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on dtack_n and berr_n; legal range 2..3.
- TIMEOUT, 64, WAIT-state cycles before the cycle is aborted with error; legal range 4..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  start-cycle strobe; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  23  word address A23..A1; sampled with req.
- be  in  2  byte enables: be[1] = upper byte (uds), be[0] = lower byte (lds); sampled with req.
- wdata  in  16  write data; sampled with req.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at cycle end.
- err  out  1  valid with done: berr or timeout.
- timeout  out  1  valid with done: the abort came from the timer.
- rdata  out  16  read data, held until the next read completes.
- bus_addr  out  23  address bus.
- bus_dout  out  16  write data.
- bus_doe  out  1  data-bus output enable.
- bus_din  in  16  data bus input.
- rw  out  1  bus read/write, 1 = read.
- as_n  out  1  address strobe.
- uds_n  out  1  upper data strobe.
- lds_n  out  1  lower data strobe.
- dtack_n  in  1  asynchronous acknowledge.
- berr_n  in  1  asynchronous bus error.

Behaviour:
- Reset (asynchronous, immediate, also mid-cycle):
  - as_n = uds_n = lds_n = 1, rw = 1, bus_doe = 0.
  - busy = done = err = timeout = 0.
  - rdata = 0, bus_addr = 0, bus_dout = 0; state = IDLE.
  - Synchronizers are reset to 1.
- dtack_s and berr_s are the SYNC_STAGES-synchronized dtack_n and berr_n. Only these are used in decisions.
- States:
  - IDLE:
    - With req = 1: capture we/addr/be/wdata, go ADDR.
    - With be = 00: no bus activity; done = 1 with err = 1 next cycle; stay IDLE.
  - ADDR:
    - bus_addr valid; rw = ~we.
    - For a write, bus_doe = 1 and bus_dout = wdata from this cycle until the END cycle inclusive.
    - Go STRB.
  - STRB:
    - as_n = 0.
    - For a read, the selected uds_n/lds_n = 0 in this same cycle. Go WAIT.
    - For a write, go WDS; WDS asserts the selected data strobes, then goes WAIT.
    - Timer cleared.
  - WAIT (all strobes held asserted):
    - berr_s = 0 → END with err = 1. This has priority over dtack.
    - Otherwise dtack_s = 0 → LATCH.
    - Otherwise timer increments; when timer == TIMEOUT-1 → END with err = 1 and timeout = 1.
  - LATCH:
    - Read: rdata <= bus_din; strobes still asserted.
    - Go END.
  - END:
    - as_n, uds_n, lds_n = 1; bus_doe = 0 at the end of this cycle.
    - done = 1 for exactly this cycle, with err and timeout.
    - Go RECOVER.
  - RECOVER:
    - Wait until dtack_s = 1 and berr_s = 1, then go IDLE. There is no timeout in this state.
    - rw returns to 1 on entry to IDLE.
- req outside IDLE is ignored; there is no queueing. The earliest next cycle starts in the cycle after RECOVER exits.
- Read latency with dtack_n already low: req at edge 0 → done at edge 5 (IDLE, ADDR, STRB, WAIT, LATCH, END). Write adds one cycle (WDS).
- rdata is unchanged on writes and on error cycles.
- as_n is never asserted while dtack_s = 0 from a previous cycle; RECOVER guarantees this.
- Only selected strobes toggle. An unselected strobe stays 1 throughout the cycle.

Test Plan:
- Read, be = 11, addr = 0x000400, bus_din = 0xA55A, dtack_n tied low → as_n/uds_n/lds_n low together. done is a single pulse with err = 0 and rdata = 0xA55A.
- Write, be = 10, wdata = 0x1234, dtack_n driven low 4 cycles after as_n falls → rw = 0 and bus_doe = 1 from ADDR. uds_n falls 1 cycle after as_n; lds_n stays 1. done with err = 0; bus_doe = 0 after END.
- dtack_n never asserted, TIMEOUT = 8 → strobes held for exactly 8 WAIT cycles. done with err = 1, timeout = 1; rdata unchanged.
- berr_n and dtack_n asserted in the same cycle → done with err = 1, timeout = 0. rdata is not updated.
- dtack_n held low 10 cycles after END, with a new req during RECOVER → req is ignored. The next cycle is accepted only after dtack_s returns high.
- Reset asserted mid-WAIT → as_n/uds_n/lds_n go high and bus_doe goes low without waiting for a clock edge. busy = 0; a subsequent req runs a normal cycle.

Source files
------------

// File: rtl/m68k_bus_initiator.sv
// m68k_bus_initiator: 68000-style async bus-cycle master issuing one read/write per request.
module m68k_bus_initiator #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [22:0] addr,
    input  logic [1:0]  be,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        timeout,
    output logic [15:0] rdata,
    output logic [22:0] bus_addr,
    output logic [15:0] bus_dout,
    output logic        bus_doe,
    input  logic [15:0] bus_din,
    output logic        rw,
    output logic        as_n,
    output logic        uds_n,
    output logic        lds_n,
    input  logic        dtack_n,
    input  logic        berr_n
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_STRB, S_WDS, S_WAIT, S_LATCH, S_END, S_RECOVER
    } state_t;

    state_t state, state_nx;
    logic [SYNC_STAGES-1:0] dsync, bsync;
    logic [7:0] tmr;
    logic       we_r, err_r, to_r, nul;
    logic [1:0] be_r;
    logic       dtack_s, berr_s, accept, expired, strb_on;

    assign dtack_s = dsync[SYNC_STAGES-1];
    assign berr_s  = bsync[SYNC_STAGES-1];
    assign accept  = state == S_IDLE && req && be != 2'b00;
    assign expired = tmr == 8'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dsync <= '1;
            bsync <= '1;
        end else begin
            dsync <= {dsync[SYNC_STAGES-2:0], dtack_n};
            bsync <= {bsync[SYNC_STAGES-2:0], berr_n};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    state_nx = accept ? S_ADDR : S_IDLE;
            S_ADDR:    state_nx = S_STRB;
            S_STRB:    state_nx = we_r ? S_WDS : S_WAIT;
            S_WDS:     state_nx = S_WAIT;
            S_WAIT:    state_nx = !berr_s ? S_END : !dtack_s ? S_LATCH : expired ? S_END : S_WAIT;
            S_LATCH:   state_nx = S_END;
            S_END:     state_nx = S_RECOVER;
            S_RECOVER: state_nx = (dtack_s && berr_s) ? S_IDLE : S_RECOVER;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r     <= 1'b0;
            be_r     <= 2'b00;
            bus_addr <= '0;
            bus_dout <= '0;
            rdata    <= '0;
            tmr      <= '0;
            err_r    <= 1'b0;
            to_r     <= 1'b0;
            nul      <= 1'b0;
        end else begin
            nul <= state == S_IDLE && req && be == 2'b00;
            if (accept) begin
                we_r     <= we;
                be_r     <= be;
                bus_addr <= addr;
                bus_dout <= wdata;
            end
            tmr <= state == S_WAIT ? tmr + 8'd1 : 8'd0;
            if (state == S_STRB) begin
                err_r <= 1'b0;
                to_r  <= 1'b0;
            end else if (state == S_WAIT && !berr_s) begin
                err_r <= 1'b1;
            end else if (state == S_WAIT && dtack_s && expired) begin
                err_r <= 1'b1;
                to_r  <= 1'b1;
            end
            if (state == S_LATCH && !we_r)
                rdata <= bus_din;
        end
    end

    // reads strobe data together with as_n; writes hold data strobes back one cycle (WDS)
    always_comb begin
        strb_on = state inside {S_WDS, S_WAIT, S_LATCH} || (state == S_STRB && !we_r);
        busy    = state != S_IDLE;
        done    = state == S_END || nul;
        err     = (state == S_END && err_r) || nul;
        timeout = state == S_END && to_r;
        as_n    = !(state inside {S_STRB, S_WDS, S_WAIT, S_LATCH});
        uds_n   = !(strb_on && be_r[1]);
        lds_n   = !(strb_on && be_r[0]);
        rw      = state == S_IDLE || !we_r;
        bus_doe = we_r && state inside {S_ADDR, S_STRB, S_WDS, S_WAIT, S_LATCH, S_END};
    end
endmodule

// File: tb/tb_m68k_bus_initiator.sv
// tb_m68k_bus_initiator: directed checks of read/write/timeout/berr/recover/reset behaviour.
module tb_m68k_bus_initiator;
    logic clk = 0, reset = 0, req = 0, we = 0;
    logic [22:0] addr = 0;
    logic [1:0]  be = 0;
    logic [15:0] wdata = 0, bus_din = 0;
    logic dtack_n = 1, berr_n = 1;
    logic busy, done, err, timeout, bus_doe, rw, as_n, uds_n, lds_n;
    logic [15:0] rdata, bus_dout;
    logic [22:0] bus_addr;
    int errors = 0, checks = 0;
    int lat, as_low, u_low, l_low;
    logic e, t;

    m68k_bus_initiator #(.SYNC_STAGES(2), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .timeout(timeout), .rdata(rdata),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_doe(bus_doe), .bus_din(bus_din),
        .rw(rw), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .dtack_n(dtack_n), .berr_n(berr_n)
    );

    always #5 clk = ~clk;

    task tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task start_req(input logic w, input logic [22:0] a, input logic [1:0] b, input logic [15:0] d);
        req = 1; we = w; addr = a; be = b; wdata = d;
        tick(1);
        req = 0;
    endtask

    // counts cycles and asserted strobes until done; lat = -1 when the bound expires
    task wait_done(output int l, output int al, output int ul, output int ll, output logic ee, output logic tt);
        l = 0; al = 0; ul = 0; ll = 0;
        while (done !== 1'b1 && l < 40) begin
            al += int'(as_n === 1'b0);
            ul += int'(uds_n === 1'b0);
            ll += int'(lds_n === 1'b0);
            tick(1);
            l++;
        end
        if (done !== 1'b1) l = -1;
        ee = err; tt = timeout;
    endtask

    task test_reset;
        #1 reset = 1;
        #2;
        checks++; if ({as_n, uds_n, lds_n, rw, bus_doe, busy, done, err, timeout} !== 9'b111100000) begin
            errors++; $display("FAIL reset_ctl: got %b expected 111100000", {as_n, uds_n, lds_n, rw, bus_doe, busy, done, err, timeout}); end
        checks++; if ({rdata, bus_addr, bus_dout} !== 55'd0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {rdata, bus_addr, bus_dout}); end
        @(negedge clk) reset = 0;
        tick(1);
    endtask

    task test_null;
        start_req(0, 23'h1, 2'b00, 16'h0);
        checks++; if ({done, err, timeout, busy, as_n} !== 5'b11001) begin
            errors++; $display("FAIL null_done: got %b expected 11001", {done, err, timeout, busy, as_n}); end
        tick(1);
        checks++; if ({done, busy} !== 2'b00) begin
            errors++; $display("FAIL null_pulse: got %b expected 00", {done, busy}); end
    endtask

    task test_read;
        dtack_n = 0; bus_din = 16'hA55A;
        tick(3);
        start_req(0, 23'h000400, 2'b11, 16'h0);
        checks++; if ({as_n, rw, busy, bus_addr} !== {3'b111, 23'h000400}) begin
            errors++; $display("FAIL read_addr: got %b %h expected 111 000400", {as_n, rw, busy}, bus_addr); end
        tick(1);
        checks++; if ({as_n, uds_n, lds_n} !== 3'b000) begin
            errors++; $display("FAIL read_strobes: got %b expected 000", {as_n, uds_n, lds_n}); end
        wait_done(lat, as_low, u_low, l_low, e, t);
        checks++; if (lat !== 3 || as_low !== 3 || u_low !== 3 || l_low !== 3 || {e, t} !== 2'b00) begin
            errors++; $display("FAIL read_done: got lat=%0d as=%0d u=%0d l=%0d err=%b to=%b expected 3 3 3 3 0 0", lat, as_low, u_low, l_low, e, t); end
        tick(1);
        checks++; if (done !== 1'b0 || rdata !== 16'hA55A) begin
            errors++; $display("FAIL read_rdata: got done=%b rdata=%h expected 0 a55a", done, rdata); end
        dtack_n = 1;
        tick(3);
        checks++; if ({busy, rw} !== 2'b01) begin
            errors++; $display("FAIL read_idle: got %b expected 01", {busy, rw}); end
    endtask

    task test_write;
        start_req(1, 23'h012345, 2'b10, 16'h1234);
        checks++; if ({rw, bus_doe, as_n, bus_dout} !== {3'b011, 16'h1234}) begin
            errors++; $display("FAIL write_addr: got %b %h expected 011 1234", {rw, bus_doe, as_n}, bus_dout); end
        tick(1);
        checks++; if ({as_n, uds_n, lds_n} !== 3'b011) begin
            errors++; $display("FAIL write_strb: got %b expected 011", {as_n, uds_n, lds_n}); end
        tick(1);
        checks++; if ({as_n, uds_n, lds_n} !== 3'b001) begin
            errors++; $display("FAIL write_wds: got %b expected 001", {as_n, uds_n, lds_n}); end
        tick(3);
        dtack_n = 0;
        wait_done(lat, as_low, u_low, l_low, e, t);
        checks++; if (lat !== 4 || as_low !== 4 || u_low !== 4 || l_low !== 0 || {e, t} !== 2'b00) begin
            errors++; $display("FAIL write_done: got lat=%0d as=%0d u=%0d l=%0d err=%b to=%b expected 4 4 4 0 0 0", lat, as_low, u_low, l_low, e, t); end
        checks++; if ({bus_doe, as_n, uds_n, lds_n} !== 4'b1111) begin
            errors++; $display("FAIL write_end: got %b expected 1111", {bus_doe, as_n, uds_n, lds_n}); end
        tick(1);
        checks++; if ({bus_doe, rw, rdata} !== {2'b00, 16'hA55A}) begin
            errors++; $display("FAIL write_recover: got %b %h expected 00 a55a", {bus_doe, rw}, rdata); end
        dtack_n = 1;
        tick(3);
        checks++; if ({busy, rw} !== 2'b01) begin
            errors++; $display("FAIL write_idle: got %b expected 01", {busy, rw}); end
    endtask

    task test_timeout;
        bus_din = 16'h0F0F;
        start_req(0, 23'h7FFFFF, 2'b01, 16'h0);
        wait_done(lat, as_low, u_low, l_low, e, t);
        checks++; if (lat !== 10 || as_low !== 9 || u_low !== 0 || l_low !== 9 || {e, t} !== 2'b11) begin
            errors++; $display("FAIL timeout_done: got lat=%0d as=%0d u=%0d l=%0d err=%b to=%b expected 10 9 0 9 1 1", lat, as_low, u_low, l_low, e, t); end
        tick(3);
        checks++; if ({busy, rdata} !== {1'b0, 16'hA55A}) begin
            errors++; $display("FAIL timeout_rdata: got %b %h expected 0 a55a", busy, rdata); end
    endtask

    task test_berr;
        dtack_n = 0; berr_n = 0; bus_din = 16'hFFFF;
        tick(3);
        start_req(0, 23'h000002, 2'b11, 16'h0);
        wait_done(lat, as_low, u_low, l_low, e, t);
        checks++; if (lat !== 3 || {e, t} !== 2'b10) begin
            errors++; $display("FAIL berr_done: got lat=%0d err=%b to=%b expected 3 1 0", lat, e, t); end
        tick(1);
        checks++; if (rdata !== 16'hA55A) begin
            errors++; $display("FAIL berr_rdata: got %h expected a55a", rdata); end
        dtack_n = 1; berr_n = 1;
        tick(3);
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL berr_idle: got %b expected 0", busy); end
    endtask

    task test_back_to_back;
        dtack_n = 0; bus_din = 16'h5AA5;
        tick(3);
        start_req(0, 23'h000100, 2'b11, 16'h0);
        wait_done(lat, as_low, u_low, l_low, e, t);
        checks++; if (lat !== 4 || e !== 1'b0) begin
            errors++; $display("FAIL b2b_first: got lat=%0d err=%b expected 4 0", lat, e); end
        tick(1);
        req = 1; addr = 23'h000200; be = 2'b11; we = 0;
        tick(1);
        req = 0;
        checks++; if ({busy, as_n, bus_addr} !== {2'b11, 23'h000100}) begin
            errors++; $display("FAIL b2b_ignore: got %b %h expected 11 000100", {busy, as_n}, bus_addr); end
        tick(8);
        dtack_n = 1;
        tick(2);
        checks++; if (busy !== 1'b1) begin
            errors++; $display("FAIL b2b_hold: got %b expected 1", busy); end
        tick(1);
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL b2b_release: got %b expected 0", busy); end
        tick(1);
        checks++; if ({busy, as_n, bus_addr, rdata} !== {2'b01, 23'h000100, 16'h5AA5}) begin
            errors++; $display("FAIL b2b_noqueue: got %b %h %h expected 01 000100 5aa5", {busy, as_n}, bus_addr, rdata); end
        dtack_n = 0; bus_din = 16'h1111;
        tick(3);
        start_req(0, 23'h000200, 2'b11, 16'h0);
        wait_done(lat, as_low, u_low, l_low, e, t);
        tick(1);
        checks++; if (lat !== 4 || e !== 1'b0 || bus_addr !== 23'h000200 || rdata !== 16'h1111) begin
            errors++; $display("FAIL b2b_second: got lat=%0d err=%b addr=%h rdata=%h expected 4 0 000200 1111", lat, e, bus_addr, rdata); end
        dtack_n = 1;
        tick(3);
    endtask

    task test_reset_midcycle;
        start_req(1, 23'h000055, 2'b11, 16'hBEEF);
        tick(3);
        checks++; if ({as_n, uds_n, lds_n, bus_doe} !== 4'b0001) begin
            errors++; $display("FAIL mid_wait: got %b expected 0001", {as_n, uds_n, lds_n, bus_doe}); end
        #2 reset = 1;
        #1;
        checks++; if ({as_n, uds_n, lds_n, bus_doe, busy, rw} !== 6'b111001) begin
            errors++; $display("FAIL mid_reset: got %b expected 111001", {as_n, uds_n, lds_n, bus_doe, busy, rw}); end
        @(negedge clk) reset = 0;
        tick(1);
        dtack_n = 0; bus_din = 16'h2222;
        tick(3);
        start_req(0, 23'h000066, 2'b11, 16'h0);
        wait_done(lat, as_low, u_low, l_low, e, t);
        tick(1);
        checks++; if (lat !== 4 || e !== 1'b0 || rdata !== 16'h2222) begin
            errors++; $display("FAIL mid_after: got lat=%0d err=%b rdata=%h expected 4 0 2222", lat, e, rdata); end
        dtack_n = 1;
        tick(3);
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL mid_idle: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset;
        test_null;
        test_read;
        test_write;
        test_timeout;
        test_berr;
        test_back_to_back;
        test_reset_midcycle;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
